// File: rtl/secure_mem_if.sv
// Request/response bundle between the security unit (master) and the
// secured memory responder (slave).
interface secure_mem_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       req_key;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              locked;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_key, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, locked
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_key, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, locked
    );
endinterface

// File: rtl/secure_mem_responder.sv
// Key-tagged encrypted word store with per-word ownership.
// Optional feature macro SECMEM_LOCKOUT_EN adds a key-failure lockout.
module secure_mem_responder #(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int FAIL_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    secure_mem_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    function automatic logic [7:0] key_tag(input logic [31:0] key);
        return key[31:24] ^ key[23:16] ^ key[15:8] ^ key[7:0];
    endfunction

    function automatic logic [31:0] key_stream(input logic [31:0] key, input logic [4:0] sh);
        logic [63:0] dbl;
        dbl = {key, key} << sh;
        return dbl[63:32];
    endfunction

    state_t            state_r;
    logic              ready_r;
    logic              resp_valid_r;
    logic              err_r;
    logic [31:0]       rdata_r;
    logic              write_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       key_r;

    logic [31:0]       mem_r     [DEPTH];
    logic [7:0]        tag_mem_r [DEPTH];
    logic [DEPTH-1:0]  owned_r;

    logic              lock_s;
    logic              in_range_s;
    logic [7:0]        tag_s;
    logic [31:0]       ks_s;
    logic              we_s;
    logic              chk_err_s;
    logic              mismatch_s;
    logic [31:0]       chk_rdata_s;

    assign in_range_s = ({1'b0, addr_r} < DEPTH_C);
    assign tag_s      = key_tag(key_r);
    assign ks_s       = key_stream(key_r, addr_r[4:0]);

    // Access decision for the latched request, evaluated during CHECK
    always_comb begin
        we_s        = 1'b0;
        chk_err_s   = 1'b0;
        mismatch_s  = 1'b0;
        chk_rdata_s = 32'd0;
        if (lock_s) begin
            chk_err_s = 1'b1;
        end else if (!in_range_s) begin
            chk_err_s = 1'b1;
        end else if (!owned_r[addr_r]) begin
            if (write_r) begin
                we_s = 1'b1;
            end else begin
                chk_rdata_s = 32'd0;
            end
        end else if (tag_mem_r[addr_r] == tag_s) begin
            if (write_r) begin
                we_s = 1'b1;
            end else begin
                chk_rdata_s = mem_r[addr_r] ^ ks_s;
            end
        end else begin
            chk_err_s  = 1'b1;
            mismatch_s = 1'b1;
        end
    end

    // Ciphertext and owner-tag storage; not reset, commits on the CHECK->RESP edge
    always_ff @(posedge clk) begin
        if (state_r == CHECK && we_s) begin
            mem_r[addr_r]     <= wdata_r ^ ks_s;
            tag_mem_r[addr_r] <= tag_s;
        end
    end

    // Request/response FSM with registered handshake outputs and ownership bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            err_r        <= 1'b0;
            rdata_r      <= 32'd0;
            write_r      <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= 32'd0;
            key_r        <= 32'd0;
            owned_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid && ready_r) begin
                        write_r <= bus.req_write;
                        addr_r  <= bus.req_addr;
                        wdata_r <= bus.req_wdata;
                        key_r   <= bus.req_key;
                        ready_r <= 1'b0;
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    if (we_s) begin
                        owned_r[addr_r] <= 1'b1;
                    end
                    resp_valid_r <= 1'b1;
                    err_r        <= chk_err_s;
                    rdata_r      <= chk_rdata_s;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        err_r        <= 1'b0;
                        rdata_r      <= 32'd0;
                        ready_r      <= 1'b1;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    ready_r      <= 1'b1;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

`ifdef SECMEM_LOCKOUT_EN
    localparam int CNT_W = $clog2(FAIL_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(FAIL_LIMIT);

    logic [CNT_W-1:0] fail_cnt_r;
    logic [CNT_W-1:0] fail_inc_s;
    logic             locked_r;

    assign fail_inc_s = (fail_cnt_r < LIMIT_C) ? fail_cnt_r + CNT_W'(1) : fail_cnt_r;
    assign lock_s     = locked_r;
    assign bus.locked = locked_r;

    // Consecutive tag-mismatch counter; lockout is sticky until reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail_cnt_r <= '0;
            locked_r   <= 1'b0;
        end else if (state_r == CHECK) begin
            if (mismatch_s) begin
                fail_cnt_r <= fail_inc_s;
                if (fail_inc_s >= LIMIT_C) begin
                    locked_r <= 1'b1;
                end
            end else if (!chk_err_s) begin
                fail_cnt_r <= '0;
            end else begin
                fail_cnt_r <= fail_cnt_r;
            end
        end
    end
`else
    localparam int unused_fail_limit = FAIL_LIMIT;
    assign lock_s     = 1'b0;
    assign bus.locked = 1'b0;
`endif

    assign bus.req_ready  = ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = rdata_r;
    assign bus.resp_err   = err_r;
endmodule

// File: tb/tb_secure_mem_responder.sv
// Directed self-checking bench for secure_mem_responder (DEPTH=200).
module tb_secure_mem_responder;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    secure_mem_if #(.ADDR_W(8)) bus ();

    secure_mem_responder #(.ADDR_W(8), .DEPTH(200), .FAIL_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic transact(input logic w, input logic [7:0] a, input logic [31:0] d,
                            input logic [31:0] k, input int hold,
                            output logic [31:0] rd, output logic e);
        int n;
        int stable;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_key   = k;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("resp_valid_seen", 32'(bus.resp_valid), 32'd1);
        rd = bus.resp_rdata;
        e  = bus.resp_err;
        if (hold > 0) begin
            stable = 0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (bus.resp_valid && !bus.req_ready && bus.resp_rdata == rd && bus.resp_err == e)
                    stable++;
            end
            check_val("backpressure_stable", 32'(stable), 32'(hold));
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic w, input logic [7:0] a,
                               input logic [31:0] d, input logic [31:0] k,
                               input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        e;
        transact(w, a, d, k, 0, rd, e);
        check_val({tag, "_rdata"}, rd, exp_rd);
        check_val({tag, "_err"}, 32'(e), 32'(exp_err));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          n;
        n_checks = 0;
        n_errors = 0;
        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 8'd0;
        bus.req_wdata  = 32'd0;
        bus.req_key    = 32'd0;
        bus.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_val("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_val("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check_val("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check_val("rst_locked", 32'(bus.locked), 32'd0);
        reset = 1'b1;

        // Basic ownership, wrong key, tag collision, range
        expect_resp("store3",        1'b1, 8'd3,   32'hDEADBEEF, 32'h12345678, 32'd0,        1'b0);
        expect_resp("load3",         1'b0, 8'd3,   32'd0,        32'h12345678, 32'hDEADBEEF, 1'b0);
        expect_resp("load3_badkey",  1'b0, 8'd3,   32'd0,        32'hAABBCCDD, 32'd0,        1'b1);
        expect_resp("store3_badkey", 1'b1, 8'd3,   32'h11111111, 32'hAABBCCDD, 32'd0,        1'b1);
        expect_resp("load3_after",   1'b0, 8'd3,   32'd0,        32'h12345678, 32'hDEADBEEF, 1'b0);
        expect_resp("load3_collide", 1'b0, 8'd3,   32'd0,        32'h08000000, 32'h0F0F0D2F, 1'b0);
        expect_resp("load250",       1'b0, 8'd250, 32'd0,        32'h12345678, 32'd0,        1'b1);
        expect_resp("store250",      1'b1, 8'd250, 32'h12345678, 32'h12345678, 32'd0,        1'b1);
        expect_resp("load5_unowned", 1'b0, 8'd5,   32'd0,        32'h12345678, 32'd0,        1'b0);
        expect_resp("store3_over",   1'b1, 8'd3,   32'hCAFEF00D, 32'h12345678, 32'd0,        1'b0);
        expect_resp("load3_over",    1'b0, 8'd3,   32'd0,        32'h12345678, 32'hCAFEF00D, 1'b0);
        expect_resp("store31",       1'b1, 8'd31,  32'h00000000, 32'h80000001, 32'd0,        1'b0);
        expect_resp("load31_rot",    1'b0, 8'd31,  32'd0,        32'h81000000, 32'h80800000, 1'b0);
        expect_resp("store199",      1'b1, 8'd199, 32'h5A5A5A5A, 32'h12345678, 32'd0,        1'b0);
        expect_resp("load199",       1'b0, 8'd199, 32'd0,        32'h12345678, 32'h5A5A5A5A, 1'b0);
        expect_resp("load200",       1'b0, 8'd200, 32'd0,        32'h12345678, 32'd0,        1'b1);

        // Back-pressure: hold RESP for 10 cycles
        transact(1'b0, 8'd3, 32'd0, 32'h12345678, 10, rd, e);
        check_val("bp_rdata", rd, 32'hCAFEF00D);
        check_val("bp_err", 32'(e), 32'd0);

        // Reset while in RESP drops the response
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'd3;
        bus.req_key   = 32'h12345678;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("rstresp_valid_before", 32'(bus.resp_valid), 32'd1);
        reset = 1'b0;
        #1;
        check_val("rstresp_dropped", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        expect_resp("load3_cleared", 1'b0, 8'd3, 32'd0, 32'h12345678, 32'd0, 1'b0);

        // Reset while in CHECK of a store: no write lands
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'd7;
        bus.req_wdata = 32'h77777777;
        bus.req_key   = 32'h12345678;
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_val("rstchk_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_val("rstchk_req_ready", 32'(bus.req_ready), 32'd1);
        reset = 1'b1;
        expect_resp("load7_unowned", 1'b0, 8'd7, 32'd0, 32'h12345678, 32'd0, 1'b0);

`ifdef SECMEM_LOCKOUT_EN
        expect_resp("lk_store3", 1'b1, 8'd3, 32'hDEADBEEF, 32'h12345678, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            expect_resp("lk_pre_bad", 1'b0, 8'd3, 32'd0, 32'hAABBCCDD, 32'd0, 1'b1);
        expect_resp("lk_good_clears", 1'b0, 8'd3, 32'd0, 32'h12345678, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 3; i++)
            expect_resp("lk_bad", 1'b0, 8'd3, 32'd0, 32'hAABBCCDD, 32'd0, 1'b1);
        check_val("lk_not_yet", 32'(bus.locked), 32'd0);
        expect_resp("lk_bad4", 1'b0, 8'd3, 32'd0, 32'hAABBCCDD, 32'd0, 1'b1);
        check_val("lk_locked", 32'(bus.locked), 32'd1);
        expect_resp("lk_owner_denied", 1'b0, 8'd3, 32'd0, 32'h12345678, 32'd0, 1'b1);
        expect_resp("lk_store_denied", 1'b1, 8'd9, 32'h99999999, 32'h12345678, 32'd0, 1'b1);
        pulse_reset();
        check_val("lk_reset_unlocked", 32'(bus.locked), 32'd0);
        expect_resp("lk_store_again", 1'b1, 8'd3, 32'hDEADBEEF, 32'h12345678, 32'd0, 1'b0);
        expect_resp("lk_load_again", 1'b0, 8'd3, 32'd0, 32'h12345678, 32'hDEADBEEF, 1'b0);
        expect_resp("lk_load9_unowned", 1'b0, 8'd9, 32'd0, 32'h12345678, 32'd0, 1'b0);
`else
        for (int i = 0; i < 5; i++)
            expect_resp("nolk_bad", 1'b0, 8'd3, 32'd0, 32'hAABBCCDD, 32'd0, 1'b0);
        expect_resp("nolk_store3", 1'b1, 8'd3, 32'hDEADBEEF, 32'h12345678, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++)
            expect_resp("nolk_mismatch", 1'b0, 8'd3, 32'd0, 32'hAABBCCDD, 32'd0, 1'b1);
        check_val("nolk_locked_tied", 32'(bus.locked), 32'd0);
        expect_resp("nolk_owner_ok", 1'b0, 8'd3, 32'd0, 32'h12345678, 32'hDEADBEEF, 1'b0);
        pulse_reset();
        check_val("nolk_after_reset", 32'(bus.locked), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/secure_mem_responder.md
Name: secure_mem_responder

Overview:
- Memory-side responder for the processor's secured load/store path.
- Accepts key-tagged read/write requests over a valid/ready handshake.
- Stores data encrypted under an address-dependent keystream, tracks a per-word owner tag, and returns decrypted data only to the owning key.
- Sits between the processor's security unit and data storage; all stored words are ciphertext.

Parameters:
- ADDR_W, 8, request address width in words.
- DEPTH, 256, number of 32-bit words; must be <= 2^ADDR_W.
- FAIL_LIMIT, 4, consecutive key failures before lockout; used only with SECMEM_LOCKOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  32  plaintext store data.
- req_key  input  32  requester access key.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  decrypted load data; 0 on stores and errors.
- resp_err  output  1  access denied or out of range.
- locked  output  1  lockout active; tied 0 without the macro.

Behaviour:
- Reset state:
  - reset low → FSM=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, locked=0.
  - All per-word owned bits are cleared. Data and tag arrays are not reset.
- Derived values:
  - tag = key[31:24]^key[23:16]^key[15:8]^key[7:0] (8 bits).
  - keystream = key rotated left by addr[4:0].
  - cipher = plaintext ^ keystream.
- FSM states: IDLE, CHECK, RESP. Each request costs a minimum of 3 cycles.
- IDLE:
  - req_ready=1; it is 0 in all other states.
  - req_valid&req_ready at a clock edge latches write, addr, wdata and key, then goes to CHECK.
- CHECK (one cycle): reads the array entry at the latched addr and evaluates the cases below.
  - Addr >= DEPTH: err=1, no array access.
  - Store to an unowned word: write cipher, write tag, set owned; err=0.
  - Store to an owned word with matching tag: overwrite cipher; err=0.
  - Store to an owned word with mismatching tag: no write; err=1.
  - Load from an owned word with matching tag: rdata = stored ^ keystream; err=0.
  - Load from an owned word with mismatching tag: rdata=0, err=1.
  - Load from an unowned word: rdata=0, err=0.
  - All array writes commit on the CHECK→RESP edge. The FSM then goes to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_valid&resp_ready.
  - On that handshake, the next edge clears resp_valid and returns the FSM to IDLE.
  - No new request is accepted in the same cycle as the handshake.
- Back-pressure: resp_ready low holds RESP indefinitely with outputs stable.
- Reset mid-operation:
  - Reset asserted in CHECK, before the edge: no array write occurs.
  - Reset asserted in RESP: the pending response is dropped.
- Tag collisions (distinct keys with equal tag) are accepted and intentional. Data still decrypts under the wrong keystream.
- A request arriving while req_ready=0 is ignored; the requester holds it.

Optional Feature:
SECMEM_LOCKOUT_EN
- Defined:
  - A saturating fail counter increments on every err=1 caused by a tag mismatch. It does not count out-of-range errors.
  - The counter clears on any err=0 response.
  - When the counter reaches FAIL_LIMIT, locked=1 is set at the CHECK→RESP edge.
  - While locked, every subsequent request responds with err=1, rdata=0, and no array write.
  - Only reset clears the lockout.
- Undefined: no counter; locked tied to 0; behaviour exactly as above.

Test Plan:
- Basic store/load:
  - Store addr=3, wdata=0xDEADBEEF, key=0x12345678 → resp err=0. Stored cipher is 0x4F0F0D2F (tag 0x08).
  - Load addr=3 with the same key → rdata=0xDEADBEEF, err=0.
- Wrong key: load addr=3 with key=0xAABBCCDD (tag 0x00) → rdata=0, err=1. Store addr=3 with that key → err=1, and a later owner load still returns 0xDEADBEEF.
- Out of range: with DEPTH=200, load addr=250 → err=1, rdata=0. Load of never-written addr=5 → rdata=0, err=0.
- Back-pressure and reset:
  - Hold resp_ready=0 for 10 cycles in RESP → resp_valid, rdata and err stable, req_ready=0.
  - Assert reset in CHECK of a store to addr=7, then load addr=7 → rdata=0, err=0 (unowned).
- Lockout (macro defined, FAIL_LIMIT=4): four mismatching loads → locked=1 after the 4th. A subsequent correct-key load → err=1. After reset → locked=0 and valid data returns.
